// File: rtl/filter_event_ctrl_pkg.sv
// Shared types and helpers for the filter event sequencer.
// States, default widths and a saturating increment used by the event counters.
package filter_event_pkg;

    localparam int SIZE_FILTER_DATA = 16;
    localparam int DEF_DATA_W       = SIZE_FILTER_DATA;
    localparam int DEF_TS_W         = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RISE,
        ST_OUTPUT,
        ST_DEAD
    } state_t;

    // Increments value, clamping at the all-ones pattern of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/filter_event_ctrl_sat_counter.sv
// Saturating event counter; clears only on reset, holds at all-ones.
module sat_counter
    import filter_event_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= CNT_W'(sat_inc(32'(cnt), CNT_W));
        end
    end

endmodule

// File: rtl/filter_event_ctrl.sv
// Post-shaper event sequencer: threshold trigger, peak capture, record handshake, dead time.
// Optional pile-up rejection is compiled in with `define PILEUP_REJECT_EN.
module filter_event_ctrl
    import filter_event_pkg::*;
#(
    parameter int DATA_W = SIZE_FILTER_DATA,
    parameter int CNT_W  = 8,
    parameter int TS_W   = DEF_TS_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] filt_data,
    input  logic                     arm_en,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic        [CNT_W-1:0]  holdoff,
    input  logic        [CNT_W-1:0]  rise_max,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic signed [DATA_W-1:0] evt_amp,
    output logic        [TS_W-1:0]   evt_ts,
    output logic        [CNT_W-1:0]  lost_cnt,
    output logic        [CNT_W-1:0]  pileup_cnt,
    output logic                     busy
);

    state_t                    state, state_next, resume_state;
    logic signed [DATA_W-1:0]  peak;
    logic        [TS_W-1:0]    ts_cnt;
    logic        [CNT_W-1:0]   dead_cnt;
    logic                      prev_above;
    logic                      above, crossing;
    logic                      capture, peak_upd, rec_load, xfer;
    logic                      dead_load, dead_dec, lost_hit, pileup_hit;
    logic                      rise_limit;

    assign above    = filt_data > threshold;
    assign crossing = above && !prev_above;
    assign busy     = !((state == ST_IDLE) || (state == ST_ARMED));

    // Where the sequencer goes once a pulse is finished (recorded or rejected).
    assign resume_state = (holdoff != '0) ? ST_DEAD : (arm_en ? ST_ARMED : ST_IDLE);

`ifdef PILEUP_REJECT_EN
    logic [CNT_W-1:0] rise_cnt;

    assign rise_limit = (rise_max != '0) && (CNT_W'(rise_cnt + 1'b1) == rise_max);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rise_cnt <= '0;
        end else if (capture) begin
            rise_cnt <= '0;
        end else if (peak_upd) begin
            rise_cnt <= rise_cnt + 1'b1;
        end
    end
`else
    logic unused_rise_max;

    assign rise_limit      = 1'b0;
    assign unused_rise_max = ^{rise_max, rise_limit};
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        peak_upd   = 1'b0;
        rec_load   = 1'b0;
        xfer       = 1'b0;
        dead_load  = 1'b0;
        dead_dec   = 1'b0;
        lost_hit   = 1'b0;
        pileup_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm_en) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (!arm_en) begin
                    state_next = ST_IDLE;
                end else if (above) begin
                    state_next = ST_RISE;
                    capture    = 1'b1;
                end
            end
            ST_RISE: begin
                if (!arm_en) begin
                    state_next = ST_IDLE;
                end else if (filt_data < peak) begin
                    state_next = ST_OUTPUT;
                    rec_load   = 1'b1;
`ifdef PILEUP_REJECT_EN
                end else if (rise_limit) begin
                    state_next = resume_state;
                    dead_load  = (holdoff != '0);
                    pileup_hit = 1'b1;
`endif
                end else begin
                    peak_upd = 1'b1;
                end
            end
            ST_OUTPUT: begin
                // arm_en is deliberately ignored here so a presented record always completes.
                lost_hit = crossing;
                if (evt_valid && evt_ready) begin
                    state_next = resume_state;
                    dead_load  = (holdoff != '0);
                    xfer       = 1'b1;
                end
            end
            ST_DEAD: begin
                if (!arm_en) begin
                    state_next = ST_IDLE;
                end else if (dead_cnt == CNT_W'(1)) begin
                    state_next = ST_ARMED;
                end else begin
                    dead_dec = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ts_cnt     <= '0;
            peak       <= '0;
            prev_above <= 1'b0;
            dead_cnt   <= '0;
            evt_valid  <= 1'b0;
            evt_amp    <= '0;
            evt_ts     <= '0;
        end else begin
            ts_cnt     <= ts_cnt + 1'b1;
            prev_above <= above;
            if (capture) begin
                peak   <= filt_data;
                evt_ts <= ts_cnt;
            end else if (peak_upd) begin
                peak <= filt_data;
            end
            if (rec_load) begin
                evt_amp   <= peak;
                evt_valid <= 1'b1;
            end else if (xfer) begin
                evt_valid <= 1'b0;
            end
            if (dead_load) begin
                dead_cnt <= holdoff;
            end else if (dead_dec) begin
                dead_cnt <= dead_cnt - 1'b1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_lost_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lost_hit),
        .cnt   (lost_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_pileup_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pileup_hit),
        .cnt   (pileup_cnt)
    );

endmodule

// File: tb/tb_filter_event_ctrl.sv
// Bench for filter_event_ctrl: directed scenarios plus random stimulus against a pulse-level model.
module tb_filter_event_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] filt_data;
    logic        arm_en;
    logic [15:0] threshold;
    logic [7:0]  holdoff;
    logic [7:0]  rise_max;
    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] evt_amp;
    logic [31:0] evt_ts;
    logic [7:0]  lost_cnt;
    logic [7:0]  pileup_cnt;
    logic        busy;

    always #5 clk = ~clk;

    filter_event_ctrl #(.DATA_W(16), .CNT_W(8), .TS_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .filt_data  (filt_data),
        .arm_en     (arm_en),
        .threshold  (threshold),
        .holdoff    (holdoff),
        .rise_max   (rise_max),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_amp    (evt_amp),
        .evt_ts     (evt_ts),
        .lost_cnt   (lost_cnt),
        .pileup_cnt (pileup_cnt),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase of the pulse life-cycle plus the record it would present.
    typedef enum int {M_IDLE, M_ARMED, M_RISE, M_OUTPUT, M_DEAD} mode_t;
    mode_t       m_mode = M_IDLE;
    int          m_peak, m_amp, m_dead, m_rise, m_lost, m_pile;
    int unsigned m_ts, m_ts_rec;
    bit          m_valid, m_prev_above;

    function automatic int sat8(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic finish_pulse();
        if (holdoff != 8'd0) begin
            m_mode = M_DEAD;
            m_dead = int'(holdoff);
        end else begin
            m_mode = arm_en ? M_ARMED : M_IDLE;
        end
    endtask

    task automatic model_tick();
        int          s, th;
        bit          above, crossing;
        int unsigned ts_now;
        s        = int'($signed(filt_data));
        th       = int'($signed(threshold));
        above    = (s > th);
        crossing = above && !m_prev_above;
        if (!reset) begin
            m_mode = M_IDLE; m_peak = 0; m_amp = 0; m_dead = 0; m_rise = 0;
            m_lost = 0; m_pile = 0; m_ts = 0; m_ts_rec = 0;
            m_valid = 1'b0; m_prev_above = 1'b0;
            return;
        end
        ts_now       = m_ts;
        m_ts         = m_ts + 1;
        m_prev_above = above;
        case (m_mode)
            M_IDLE:  if (arm_en) m_mode = M_ARMED;
            M_ARMED: begin
                if (!arm_en) m_mode = M_IDLE;
                else if (above) begin
                    m_mode = M_RISE; m_peak = s; m_ts_rec = ts_now; m_rise = 0;
                end
            end
            M_RISE: begin
                if (!arm_en) m_mode = M_IDLE;
                else if (s < m_peak) begin
                    m_amp = m_peak; m_valid = 1'b1; m_mode = M_OUTPUT;
                end else begin
                    m_peak = s;
`ifdef PILEUP_REJECT_EN
                    m_rise++;
                    if (rise_max != 8'd0 && m_rise == int'(rise_max)) begin
                        m_pile = sat8(m_pile);
                        finish_pulse();
                    end
`endif
                end
            end
            M_OUTPUT: begin
                if (crossing) m_lost = sat8(m_lost);
                if (evt_ready) begin
                    m_valid = 1'b0;
                    finish_pulse();
                end
            end
            M_DEAD: begin
                if (!arm_en) m_mode = M_IDLE;
                else if (m_dead == 1) m_mode = M_ARMED;
                else m_dead--;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic compare_all();
        bit bz;
        bz = (m_mode == M_RISE) || (m_mode == M_OUTPUT) || (m_mode == M_DEAD);
        check("model_valid",  {63'd0, evt_valid},  {63'd0, m_valid});
        check("model_amp",    {48'd0, evt_amp},    {48'd0, m_amp[15:0]});
        check("model_ts",     {32'd0, evt_ts},     {32'd0, m_ts_rec});
        check("model_lost",   {56'd0, lost_cnt},   {56'd0, m_lost[7:0]});
        check("model_pileup", {56'd0, pileup_cnt}, {56'd0, m_pile[7:0]});
        check("model_busy",   {63'd0, busy},       {63'd0, bz});
    endtask

    task automatic step(input int sample);
        filt_data = sample[15:0];
        model_tick();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin : main
        int          p1[8];
        int          vcount;
        int          v;
        int          smp;
        int unsigned ts_exp;

        reset = 1'b0; arm_en = 1'b1; evt_ready = 1'b0; threshold = 16'd100;
        holdoff = 8'd0; rise_max = 8'd0; filt_data = 16'd500;
        step(500);
        step(500);
        reset = 1'b1;
        check("rst_valid",  {63'd0, evt_valid},  64'd0);
        check("rst_amp",    {48'd0, evt_amp},    64'd0);
        check("rst_ts",     {32'd0, evt_ts},     64'd0);
        check("rst_lost",   {56'd0, lost_cnt},   64'd0);
        check("rst_pileup", {56'd0, pileup_cnt}, 64'd0);
        check("rst_busy",   {63'd0, busy},       64'd0);
        step(500);
        check("idle_no_trig", {63'd0, busy}, 64'd0);
        step(0);
        step(0);

        // Single pulse with evt_ready held high
        evt_ready = 1'b1;
        p1 = '{0, 50, 150, 300, 420, 420, 380, 0};
        vcount = 0;
        ts_exp = 0;
        for (int i = 0; i < 8; i++) begin
            if (p1[i] == 150) ts_exp = m_ts;
            step(p1[i]);
            if (evt_valid) vcount++;
            if (i == 6) begin
                check("p1_valid", {63'd0, evt_valid}, 64'd1);
                check("p1_amp",   {48'd0, evt_amp},   64'd420);
                check("p1_ts",    {32'd0, evt_ts},    {32'd0, ts_exp});
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(0);
            if (evt_valid) vcount++;
        end
        check("p1_one_cycle", 64'(vcount), 64'd1);

        // Stalled downstream: record held, later crossings counted as lost
        evt_ready = 1'b0;
        step(0);
        ts_exp = m_ts;
        step(200);
        step(300);
        step(50);
        for (int k = 1; k <= 20; k++) begin
            smp = (k == 2 || k == 7) ? 150 : (k == 3 || k == 8) ? 250 : 0;
            step(smp);
            check("stall_valid", {63'd0, evt_valid}, 64'd1);
            check("stall_amp",   {48'd0, evt_amp},   64'd300);
            check("stall_ts",    {32'd0, evt_ts},    {32'd0, ts_exp});
        end
        check("stall_lost", {56'd0, lost_cnt}, 64'd2);
        evt_ready = 1'b1;
        step(0);
        check("stall_release", {63'd0, evt_valid}, 64'd0);

        // Dead time of 10 cycles after a transfer
        holdoff = 8'd10;
        step(0); step(200); step(300); step(50); step(0);
        check("dead_entry", {63'd0, busy}, 64'd1);
        for (int k = 1; k <= 15; k++) begin
            smp = (k == 5 || k == 12) ? 200 : (k == 6 || k == 13) ? 300 : (k == 7 || k == 14) ? 50 : 0;
            if (k == 12) ts_exp = m_ts;
            step(smp);
            if (k == 9)  check("dead_busy_last", {63'd0, busy}, 64'd1);
            if (k == 10) check("dead_expired",   {63'd0, busy}, 64'd0);
            if (k <= 13) check("dead_ignored",   {63'd0, evt_valid}, 64'd0);
            if (k == 14) begin
                check("dead_rec_valid", {63'd0, evt_valid}, 64'd1);
                check("dead_rec_amp",   {48'd0, evt_amp},   64'd300);
                check("dead_rec_ts",    {32'd0, evt_ts},    {32'd0, ts_exp});
                check("dead_lost",      {56'd0, lost_cnt},  64'd2);
            end
        end
        for (int k = 0; k < 12; k++) step(0);

        // Monotonic six-sample rise against rise_max=3
        rise_max = 8'd3;
        p1 = '{0, 110, 120, 130, 140, 150, 160, 0};
        vcount = 0;
        v = 0;
        for (int i = 0; i < 20; i++) begin
            step((i < 8) ? p1[i] : 0);
            if (evt_valid) begin
                vcount++;
                v = int'(evt_amp);
            end
        end
`ifdef PILEUP_REJECT_EN
        check("pile_no_record", 64'(vcount), 64'd0);
        check("pile_cnt",       {56'd0, pileup_cnt}, 64'd1);
`else
        check("pile_record",    64'(vcount), 64'd1);
        check("pile_amp",       64'(v), 64'd160);
        check("pile_cnt_off",   {56'd0, pileup_cnt}, 64'd0);
`endif
        rise_max = 8'd0;
        holdoff  = 8'd0;
        step(0);

        // arm_en dropped during RISE, then during OUTPUT
        evt_ready = 1'b1;
        step(0); step(200); step(300);
        arm_en = 1'b0;
        step(400);
        check("drop_rise_idle",  {63'd0, busy},      64'd0);
        check("drop_rise_norec", {63'd0, evt_valid}, 64'd0);
        step(500);
        step(0);
        arm_en = 1'b1;
        step(0);
        evt_ready = 1'b0;
        step(200); step(300); step(50);
        arm_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(0);
            check("drop_out_hold", {63'd0, evt_valid}, 64'd1);
            check("drop_out_busy", {63'd0, busy},      64'd1);
        end
        evt_ready = 1'b1;
        step(0);
        check("drop_out_done", {63'd0, evt_valid}, 64'd0);
        check("drop_out_idle", {63'd0, busy},      64'd0);
        step(200);
        check("drop_idle_stays", {63'd0, busy}, 64'd0);
        step(0);

        // Random traffic
        threshold = 16'($urandom_range(0, 300)) - 16'd100;
        rise_max  = 8'($urandom_range(0, 5));
        holdoff   = 8'($urandom_range(0, 6));
        arm_en    = 1'b1;
        v = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 5) v = int'($urandom_range(0, 900)) - 300;
            else v = v + int'($urandom_range(0, 160)) - 80;
            if (v > 800)  v = 800;
            if (v < -500) v = -500;
            evt_ready = ($urandom_range(0, 99) < 60);
            arm_en    = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 99) < 2) holdoff = 8'($urandom_range(0, 6));
            step(v);
        end

        // lost_cnt saturation under a long stall
        threshold = 16'd100; rise_max = 8'd0; holdoff = 8'd0;
        arm_en = 1'b1; evt_ready = 1'b1;
        for (int k = 0; k < 15; k++) step(0);
        evt_ready = 1'b0;
        step(200); step(300); step(50);
        for (int k = 0; k < 600; k++) step((k % 2 == 1) ? 200 : 0);
        check("lost_saturated", {56'd0, lost_cnt}, 64'd255);
        check("lost_hold_valid", {63'd0, evt_valid}, 64'd1);
        evt_ready = 1'b1;
        step(0);

        // Counters clear only on reset
        reset = 1'b0;
        step(0);
        check("rst2_lost",   {56'd0, lost_cnt},   64'd0);
        check("rst2_pileup", {56'd0, pileup_cnt}, 64'd0);
        check("rst2_ts",     {32'd0, evt_ts},     64'd0);
        check("rst2_busy",   {63'd0, busy},       64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
